// File: rtl/serial_ram_pkg.sv
// Shared geometry for the serial RAM port. The read master and the RAM model
// both import this package, so the two sides always agree on pin count and
// frame length.
//   PINS / LOG2_CYCLES / CYCLES / WORD_BITS : pin and frame geometry
//   DEFAULT_READ_LATENCY                    : first address nibble -> first data nibble
//   DEFAULT_TAG_BITS                        : opaque request tag width
package serial_ram_pkg;

  localparam int PINS                 = 4;
  localparam int LOG2_CYCLES          = 2;
  localparam int CYCLES               = 1 << LOG2_CYCLES;
  localparam int WORD_BITS            = PINS * CYCLES;
  localparam int DEFAULT_READ_LATENCY = 8;
  localparam int DEFAULT_TAG_BITS     = 2;

  typedef logic [LOG2_CYCLES-1:0] phase_t;
  typedef logic [PINS-1:0]        nibble_t;
  typedef logic [WORD_BITS-1:0]   word_t;

  typedef enum logic {
    DESER_IDLE    = 1'b0,
    DESER_CAPTURE = 1'b1
  } deser_state_e;

  // True on the last cycle of a frame, the only cycle a request is taken.
  function automatic logic is_last_phase(input phase_t p);
    return p == phase_t'(CYCLES - 1);
  endfunction

endpackage

// File: rtl/serial_ram_deser.sv
// Data-side deserializer. When start is seen, data_in is captured as nibble 0
// and the following CYCLES-1 cycles supply nibbles 1..CYCLES-1 (LSB nibble
// first). The cycle after the last nibble, rsp_valid pulses for one cycle;
// rsp_data / rsp_tag hold until the next response.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : first data nibble of a read is on data_in this cycle
//   start_tag  : tag of that read
//   data_in    : serial data nibble from RAM
//   rsp_valid  : one-cycle response strobe
//   rsp_data   : assembled word
//   rsp_tag    : tag of the read
module serial_ram_deser
  import serial_ram_pkg::*;
#(
  parameter int TAG_BITS = DEFAULT_TAG_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [TAG_BITS-1:0] start_tag,
  input  nibble_t             data_in,
  output logic                rsp_valid,
  output word_t               rsp_data,
  output logic [TAG_BITS-1:0] rsp_tag
);

  deser_state_e        state, state_next;
  phase_t              slot;       // nibble index being captured; 0 while idle
  word_t               buf_q;
  word_t               word_next;
  logic [TAG_BITS-1:0] tag_q;
  logic                capture;
  logic                last;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missed branch would otherwise infer a latch.
    state_next = state;
    capture    = 1'b0;
    last       = 1'b0;
    word_next  = buf_q;
    unique case (state)
      DESER_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = DESER_CAPTURE;
        end
      end
      DESER_CAPTURE: begin
        capture = 1'b1;
        if (slot == phase_t'(CYCLES - 1)) begin
          last       = 1'b1;
          state_next = DESER_IDLE;
        end
      end
      default: state_next = DESER_IDLE;
    endcase
    if (capture) word_next[PINS*int'(slot) +: PINS] = data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= DESER_IDLE;
      slot      <= '0;
      buf_q     <= '0;
      tag_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= last;
      if (capture) begin
        // Wraps back to 0 after the last nibble, ready for the next window.
        slot  <= slot + 1'b1;
        buf_q <= word_next;
      end
      if (state == DESER_IDLE && start) tag_q <= start_tag;
      if (last) begin
        rsp_data <= word_next;
        rsp_tag  <= tag_q;
      end
    end
  end

endmodule

// File: rtl/serial_ram_reader.sv
// Read-side master for the external serial RAM port. One word-read request is
// taken per frame (on the last frame phase), its address is driven LSB nibble
// first on addr_out during the next frame, and the returned data nibbles are
// re-assembled into a word with a response strobe. The phase counter restarts
// from reset in lockstep with the RAM device's own frame counter.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only at phase CYCLES-1)
//   req_addr, req_tag    : word address and opaque tag
//   addr_out             : serial address nibble to RAM
//   data_in              : serial data nibble from RAM
//   rsp_valid            : one-cycle response strobe
//   rsp_data, rsp_tag    : read word and its tag, held until the next response
module serial_ram_reader
  import serial_ram_pkg::*;
#(
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
  parameter int TAG_BITS     = DEFAULT_TAG_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  word_t               req_addr,
  input  logic [TAG_BITS-1:0] req_tag,
  output nibble_t             addr_out,
  input  nibble_t             data_in,
  output logic                rsp_valid,
  output word_t               rsp_data,
  output logic [TAG_BITS-1:0] rsp_tag
);

  phase_t              phase;
  logic                issue;      // current frame carries an accepted request
  word_t               addr_q;
  logic [TAG_BITS-1:0] tag_q;
  logic                entry;

  // In-flight tracking: one stage per cycle of read latency.
  logic [READ_LATENCY-1:0] dl_valid;
  logic [TAG_BITS-1:0]     dl_tag [READ_LATENCY];

  assign req_ready = is_last_phase(phase);
  assign addr_out  = issue ? addr_q[PINS*int'(phase) +: PINS] : '0;
  assign entry     = issue && (phase == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= '0;
      issue  <= 1'b0;
      addr_q <= '0;
      tag_q  <= '0;
    end else begin
      phase <= phase + 1'b1;
      // The issue flag is re-decided at every frame boundary, so a frame
      // without an accepted request drives zeros.
      if (req_ready) begin
        issue <= req_valid;
        if (req_valid) begin
          addr_q <= req_addr;
          tag_q  <= req_tag;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the delay line is a register chain, not a RAM, and every stage is
      // reset so reads in flight at reset can never produce a response.
      dl_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dl_tag[i] <= '0;
    end else begin
      dl_valid[0] <= entry;
      dl_tag[0]   <= tag_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_tag[i]   <= dl_tag[i-1];
      end
    end
  end

  // The last stage becomes valid exactly when the first data nibble is on
  // data_in: READ_LATENCY cycles after the first address nibble.
  serial_ram_deser #(
    .TAG_BITS (TAG_BITS)
  ) u_deser (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (dl_valid[READ_LATENCY-1]),
    .start_tag (dl_tag[READ_LATENCY-1]),
    .data_in   (data_in),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag)
  );

endmodule

// File: tb/tb_serial_ram_reader.sv
// Self-checking bench for serial_ram_reader. A frame-locked RAM model answers
// the address nibbles seen on addr_out; a scoreboard predicts each response
// (cycle, data, tag) from the accepted requests.
module tb_serial_ram_reader;
  import serial_ram_pkg::*;

  localparam int L  = DEFAULT_READ_LATENCY;
  localparam int TB = DEFAULT_TAG_BITS;
  localparam int HIST = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  word_t         req_addr;
  logic [TB-1:0] req_tag;
  nibble_t       addr_out;
  nibble_t       data_in;
  logic          rsp_valid;
  word_t         rsp_data;
  logic [TB-1:0] rsp_tag;

  serial_ram_reader #(
    .READ_LATENCY (L),
    .TAG_BITS     (TB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_tag   (req_tag),
    .addr_out  (addr_out),
    .data_in   (data_in),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    word_t         data;
    logic [TB-1:0] tag;
  } exp_t;

  word_t   mem [65536];
  nibble_t hist [HIST];
  exp_t    exp_q [$];
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  int      rsp_count = 0;
  word_t   last_data = '0;
  logic [TB-1:0] last_tag = '0;

  // Frame model state (bench's own view of frames since reset)
  logic  pend_valid = 1'b0, frame_valid = 1'b0;
  word_t pend_addr = '0, frame_addr = '0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request so it is high during the next phase CYCLES-1 cycle.
  task automatic send(input word_t a, input logic [TB-1:0] t);
    int guard = 0;
    while ((cyc % CYCLES) != CYCLES - 1 && guard < 2 * CYCLES) begin
      step();
      guard++;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_tag   = t;
    step();
    req_valid = 1'b0;
  endtask

  // Mid-cycle monitor: pin protocol checks, RAM device model, scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc         = 0;
      data_in     = '0;
      pend_valid  = 1'b0;
      frame_valid = 1'b0;
      exp_q.delete();
    end else begin
      int    p, k, f;
      logic  exp_now;
      word_t a, w;
      p = cyc % CYCLES;
      if (p == 0) begin
        frame_valid = pend_valid;
        frame_addr  = pend_addr;
        pend_valid  = 1'b0;
      end
      check("req_ready", req_ready, p == CYCLES - 1);
      check("addr_out", addr_out, frame_valid ? frame_addr[PINS*p +: PINS] : '0);

      // RAM device: data nibble k of the frame starting at f is driven at f+L+k.
      hist[cyc % HIST] = addr_out;
      if (cyc >= L) begin
        k = (cyc - L) % CYCLES;
        f = cyc - L - k;
        a = '0;
        for (int j = 0; j < CYCLES; j++) a[PINS*j +: PINS] = hist[(f + j) % HIST];
        w = mem[a];
        data_in = w[PINS*k +: PINS];
      end else begin
        data_in = '0;
      end

      exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("rsp_valid", rsp_valid, exp_now);
      if (rsp_valid) begin
        rsp_count++;
        last_data = rsp_data;
        last_tag  = rsp_tag;
        if (exp_now) begin
          check("rsp_data", rsp_data, exp_q[0].data);
          check("rsp_tag", rsp_tag, exp_q[0].tag);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());

      if (p == CYCLES - 1 && req_valid) begin
        pend_valid = 1'b1;
        pend_addr  = req_addr;
        exp_q.push_back('{cyc: cyc + 1 + L + CYCLES, data: mem[req_addr], tag: req_tag});
      end
      cyc++;
    end
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_tag   = '0;
    data_in   = '0;
    for (int i = 0; i < 65536; i++) mem[i] = WORD_BITS'($urandom);
    mem[16'h1234] = 16'hBEEF;
    mem[16'h0001] = 16'hA001;
    mem[16'h0002] = 16'hA002;
    mem[16'h0003] = 16'hA003;

    repeat (3) step();
    check("reset_req_ready", req_ready, 1'b0);
    check("reset_addr_out", addr_out, 0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_tag", rsp_tag, 0);
    rst_n = 1'b1;

    // Idle frames: ready pulses, zero pins, no responses
    repeat (100) step();
    check("idle_rsp_count", rsp_count, 0);

    // Single read
    base = rsp_count;
    send(16'h1234, 2'd2);
    repeat (16) step();
    check("single_count", rsp_count, base + 1);
    check("single_data", last_data, 16'hBEEF);
    check("single_tag", last_tag, 2'd2);

    // Back-to-back reads
    base = rsp_count;
    send(16'h0001, 2'd1);
    send(16'h0002, 2'd2);
    send(16'h0003, 2'd3);
    repeat (24) step();
    check("b2b_count", rsp_count, base + 3);
    check("b2b_last_data", last_data, 16'hA003);
    check("b2b_last_tag", last_tag, 2'd3);

    // Request held from phase 0: taken only at the last phase, once
    base = rsp_count;
    while ((cyc % CYCLES) != 0) step();
    req_valid = 1'b1;
    req_addr  = 16'h0002;
    req_tag   = 2'd1;
    repeat (CYCLES) step();
    req_valid = 1'b0;
    repeat (20) step();
    check("held_count", rsp_count, base + 1);
    check("held_data", last_data, 16'hA002);

    // Reset in the middle of a read drops it
    send(16'h1234, 2'd3);
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_rsp_data", rsp_data, 0);
    check("midrst_req_ready", req_ready, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    base = rsp_count;
    repeat (20) step();
    check("midrst_no_rsp", rsp_count, base);
    send(16'h0003, 2'd0);
    repeat (16) step();
    check("postrst_count", rsp_count, base + 1);
    check("postrst_data", last_data, 16'hA003);
    check("postrst_tag", last_tag, 2'd0);

    // Random sweep with random idle gaps
    base = rsp_count;
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 6)) step();
      send(WORD_BITS'($urandom), TB'($urandom));
    end
    repeat (24) step();
    check("sweep_count", rsp_count, base + 256);
    check("sweep_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
